alu_op_decoder: RTL and testbench
=================================

// Module: alu_op_decoder
// PURPOSE
//  Issue-side producer of the alu_op encoding: decodes RV32 OP/OP-IMM instructions into
//  alu_op, operand select and immediate for the execute-stage ALU. Sits between decode
//  and execute with valid/ready handshakes on both sides. A 2-entry skid buffer gives full
//  throughput. Flags undecodable OP/OP-IMM encodings as illegal.
// PARAMETERS
//  XLEN  32  operand/immediate width (only 32 supported)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-low reset (0 = reset)
//  in_valid   in   1   instruction word valid
//  in_ready   out  1   decoder can accept
//  instr      in   32  RV32 instruction word
//  out_valid  out  1   decoded bundle valid
//  out_ready  in   1   execute stage accepts bundle
//  alu_op     out  5   `ADD/`SUB/`SUBU/`AND/`OR/`XOR/`LSHIFT/`LRSHIFT/`ARSHIFT/`MUL/`DIV/`DIVU/`REM/`REMU
//  use_imm    out  1   r2 operand = imm (OP-IMM), else rs2 value
//  imm        out  32  sign-extended I-imm; shifts: zero-extended shamt instr[24:20]
//  set_lt     out  1   SLT/SLTI/SLTU/SLTIU: writeback = less-than from sub, not res
//  is_alu     out  1   instruction is OP/OP-IMM
//  rd,rs1,rs2 out  5   register fields, passed through
//  illegal    out  1   OP/OP-IMM encoding not decodable
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, skid empty; alu_op=`ADD, imm=0, all flags/fields 0.
//  - Transfer on valid&ready at posedge. in_ready = !skid_full (registered). Latency 1 cycle.
//  - Storage: main reg M (drives outputs) + skid S. Accept while M empty or draining -> M;
//    accept while M held (out_valid&!out_ready) -> S, in_ready drops next cycle.
//    Drain with S full -> M<=S, S empty, in_ready=1. No bundle dropped/duplicated/reordered.
//  - Simultaneous accept+drain with S empty: M<=new bundle, out_valid stays 1.
//  - Outputs stable while out_valid&!out_ready.
//  - OP (0110011): f7=0000000: 000 ADD,001 LSHIFT,010 SUB+set_lt,011 SUBU+set_lt,100 XOR,
//    101 LRSHIFT,110 OR,111 AND. f7=0100000: 000 SUB, 101 ARSHIFT, else illegal.
//  - OP-IMM (0010011): 000 ADD,010 SUB+set_lt,011 SUBU+set_lt,100 XOR,110 OR,111 AND;
//    001 LSHIFT needs f7=0; 101 f7=0 LRSHIFT / f7=0100000 ARSHIFT; other f7 illegal.
//  - Other opcodes: is_alu=0, alu_op=`ADD, illegal=0 (owned by other decoders).
//  - Illegal: alu_op=`ADD, is_alu=1, illegal=1; bundle still flows (trap raised downstream).
//  - Reset mid-transfer: both entries discarded, no output asserted the following cycle.
// CONFIGURATION
//  RV32M_EN defined: OP f7=0000001: 000 MUL,100 DIV,101 DIVU,110 REM,111 REMU;
//    001/010/011 (MULH/MULHSU/MULHU) illegal.
//  RV32M_EN undefined: every f7=0000001 OP encoding illegal; M codes never emitted.
// STRUCTURE
//  - Opcode/funct constants and a packed decoded-bundle layout in cpu/defines.vh beside alu_op codes.
//  - One sub-module: alu_op_decode_comb (pure combinational instr -> bundle); top holds skid logic.
// TESTING
//  - reset low 2 cycles: out_valid=0, in_ready=1, alu_op=`ADD, illegal=0.
//  - instr=0x40B50533 (sub a0,a0,a1), out_ready=1 -> next cycle alu_op=`SUB, use_imm=0, rd=10.
//  - instr=0xFFF50513 (addi a0,a0,-1) -> alu_op=`ADD, use_imm=1, imm=0xFFFFFFFF.
//  - instr=0x4055D513 (srai a0,a1,5) -> `ARSHIFT, imm=5; 0x2055D513 -> illegal=1.
//  - out_ready=0, 3 back-to-back valids -> 2 accepted, in_ready=0; release -> emitted in order.
//  - 0x02B54533 (div): RV32M_EN -> `DIV, illegal=0; without -> illegal=1; 0x02B51533 (mulh) illegal=1.

Source files
------------

// File: rtl/alu_op_decoder_pkg.sv
// Shared alu_op codes, RV32 OP/OP-IMM opcode/funct constants and the decoded-bundle layout.
// The bundle is what the skid storage holds and what the execute stage sees.
package alu_op_decoder_pkg;

  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_SUB     = 5'd1;
  localparam logic [4:0] ALU_SUBU    = 5'd2;
  localparam logic [4:0] ALU_AND     = 5'd3;
  localparam logic [4:0] ALU_OR      = 5'd4;
  localparam logic [4:0] ALU_XOR     = 5'd5;
  localparam logic [4:0] ALU_LSHIFT  = 5'd6;
  localparam logic [4:0] ALU_LRSHIFT = 5'd7;
  localparam logic [4:0] ALU_ARSHIFT = 5'd8;
  localparam logic [4:0] ALU_MUL     = 5'd9;
  localparam logic [4:0] ALU_DIV     = 5'd10;
  localparam logic [4:0] ALU_DIVU    = 5'd11;
  localparam logic [4:0] ALU_REM     = 5'd12;
  localparam logic [4:0] ALU_REMU    = 5'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic        use_imm;
    logic [31:0] imm;
    logic        set_lt;
    logic        is_alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } alu_bundle_t;

  function automatic logic [31:0] shamt_imm(input logic [31:0] w);
    return {27'b0, w[24:20]};
  endfunction

  function automatic logic [31:0] i_imm(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

endpackage

// File: rtl/alu_op_decode_comb.sv
// Pure combinational RV32 OP/OP-IMM decode into an alu_bundle_t.
// Define RV32M_EN to decode the M-extension (f7=0000001) encodings.
module alu_op_decode_comb
  import alu_op_decoder_pkg::*;
(
  input  logic [31:0]  instr,
  output alu_bundle_t  dec
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    legal      = 1'b1;
    case (instr[6:0])
      OPC_OP: begin
        dec.is_alu = 1'b1;
        case (f7)
          F7_BASE: begin
            case (f3)
              3'b000: dec.alu_op = ALU_ADD;
              3'b001: dec.alu_op = ALU_LSHIFT;
              3'b010: begin dec.alu_op = ALU_SUB;  dec.set_lt = 1'b1; end
              3'b011: begin dec.alu_op = ALU_SUBU; dec.set_lt = 1'b1; end
              3'b100: dec.alu_op = ALU_XOR;
              3'b101: dec.alu_op = ALU_LRSHIFT;
              3'b110: dec.alu_op = ALU_OR;
              default: dec.alu_op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
            else if (f3 == 3'b101) dec.alu_op = ALU_ARSHIFT;
            else                   legal = 1'b0;
          end
          F7_MULDIV: begin
`ifdef RV32M_EN
            // MULH/MULHSU/MULHU have no ALU code here, so they trap as illegal.
            case (f3)
              3'b000:  dec.alu_op = ALU_MUL;
              3'b100:  dec.alu_op = ALU_DIV;
              3'b101:  dec.alu_op = ALU_DIVU;
              3'b110:  dec.alu_op = ALU_REM;
              3'b111:  dec.alu_op = ALU_REMU;
              default: legal = 1'b0;
            endcase
`else
            legal = 1'b0;
`endif
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        dec.is_alu  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = i_imm(instr);
        case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: begin dec.alu_op = ALU_SUB;  dec.set_lt = 1'b1; end
          3'b011: begin dec.alu_op = ALU_SUBU; dec.set_lt = 1'b1; end
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.imm = shamt_imm(instr);
            if (f7 == F7_BASE) dec.alu_op = ALU_LSHIFT;
            else               legal = 1'b0;
          end
          default: begin
            dec.imm = shamt_imm(instr);
            if (f7 == F7_BASE)     dec.alu_op = ALU_LRSHIFT;
            else if (f7 == F7_ALT) dec.alu_op = ALU_ARSHIFT;
            else                   legal = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
    // Illegal encodings still flow so the trap is raised downstream.
    if (!legal) begin
      dec.alu_op  = ALU_ADD;
      dec.set_lt  = 1'b0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Issue-side ALU op decoder with a 2-entry skid buffer (main reg M + skid S).
// Optional M-extension decode enabled by defining RV32M_EN.
module alu_op_decoder
  import alu_op_decoder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      alu_op,
  output logic            use_imm,
  output logic [XLEN-1:0] imm,
  output logic            set_lt,
  output logic            is_alu,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            illegal
);

  alu_bundle_t dec, m_q, s_q;
  logic        m_vld, s_vld;
  logic        accept, drain;

  alu_op_decode_comb u_dec (
    .instr (instr),
    .dec   (dec)
  );

  assign in_ready = !s_vld;
  assign accept   = in_valid && in_ready;
  assign drain    = m_vld && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else if (s_vld) begin
      // Skid full: input is blocked, only a drain can move things.
      if (drain) begin
        m_q   <= s_q;
        s_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!m_vld || out_ready) begin
        m_q   <= dec;
        m_vld <= 1'b1;
      end else begin
        s_q   <= dec;
        s_vld <= 1'b1;
      end
    end else if (drain) begin
      m_vld <= 1'b0;
    end
  end

  assign out_valid = m_vld;
  assign alu_op    = m_q.alu_op;
  assign use_imm   = m_q.use_imm;
  assign imm       = m_q.imm;
  assign set_lt    = m_q.set_lt;
  assign is_alu    = m_q.is_alu;
  assign rd        = m_q.rd;
  assign rs1       = m_q.rs1;
  assign rs2       = m_q.rs2;
  assign illegal   = m_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Randomized bench for alu_op_decoder: table-driven reference decode plus a queue scoreboard.
// Honors RV32M_EN the same way the design does.
module tb_alu_op_decoder;
  import alu_op_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, imm;
  logic [4:0]  alu_op, rd, rs1, rs2;
  logic        use_imm, set_lt, is_alu, illegal;

  int n_chk = 0;
  int n_fail = 0;
  alu_bundle_t q[$];

`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  // funct3-indexed op tables; -1 marks "no operation".
  localparam int BASE_OP [8] = '{ALU_ADD, ALU_LSHIFT, ALU_SUB, ALU_SUBU,
                                 ALU_XOR, ALU_LRSHIFT, ALU_OR, ALU_AND};
  localparam int MD_OP   [8] = '{ALU_MUL, -1, -1, -1, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

  alu_op_decoder #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .use_imm(use_imm),
    .imm(imm), .set_lt(set_lt), .is_alu(is_alu), .rd(rd), .rs1(rs1), .rs2(rs2),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic alu_bundle_t model(input logic [31:0] w);
    alu_bundle_t e;
    int f3, f7, op;
    bit shift;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    e = '0;
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    op = ALU_ADD;
    if (w[6:0] == 7'h33) begin
      e.is_alu = 1'b1;
      op = -1;
      if (f7 == 0) begin
        op = BASE_OP[f3];
        e.set_lt = (f3 == 2 || f3 == 3);
      end
      else if (f7 == 'h20 && f3 == 0) op = ALU_SUB;
      else if (f7 == 'h20 && f3 == 5) op = ALU_ARSHIFT;
      else if (f7 == 1 && M_EN)       op = MD_OP[f3];
    end else if (w[6:0] == 7'h13) begin
      e.is_alu = 1'b1;
      e.use_imm = 1'b1;
      shift = (f3 == 1 || f3 == 5);
      e.imm = shift ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      if (!shift) begin
        op = BASE_OP[f3];
        e.set_lt = (f3 == 2 || f3 == 3);
      end
      else if (f3 == 1) op = (f7 == 0) ? ALU_LSHIFT : -1;
      else              op = (f7 == 0) ? ALU_LRSHIFT : (f7 == 'h20) ? ALU_ARSHIFT : -1;
    end
    if (op < 0) begin
      e.illegal = 1'b1;
      e.set_lt = 1'b0;
      e.alu_op = ALU_ADD;
    end else begin
      e.alu_op = op[4:0];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic alu_bundle_t observed();
    alu_bundle_t g;
    g.alu_op = alu_op; g.use_imm = use_imm; g.imm = imm; g.set_lt = set_lt;
    g.is_alu = is_alu; g.rd = rd; g.rs1 = rs1; g.rs2 = rs2; g.illegal = illegal;
    return g;
  endfunction

  task automatic check_state();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() != 0) chk("bundle", 64'(observed()), 64'(q[0]));
  endtask

  // Called just after a negedge; returns at the next negedge with outputs checked.
  task automatic step(input logic v, input logic [31:0] w, input logic r);
    logic acc, drn;
    in_valid = v; instr = w; out_ready = r;
    acc = v && in_ready && reset;
    drn = out_valid && r && reset;
    @(posedge clk);
    if (!reset) q.delete();
    else begin
      if (drn && q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back(model(w));
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic dir(input string tag, input logic [31:0] w, input logic [4:0] op,
                     input logic ui, input logic [31:0] im, input logic ill);
    step(1'b1, w, 1'b1);
    chk({tag, ".alu_op"}, 64'(alu_op), 64'(op));
    chk({tag, ".use_imm"}, 64'(use_imm), 64'(ui));
    chk({tag, ".imm"}, 64'(imm), 64'(im));
    chk({tag, ".illegal"}, 64'(illegal), 64'(ill));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc, f7;
    r = $urandom();
    case ($urandom_range(0, 3))
      0, 1:    opc = OPC_OP;
      2:       opc = OPC_OPIMM;
      default: opc = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0:       f7 = F7_BASE;
      1:       f7 = F7_ALT;
      2:       f7 = F7_MULDIV;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], opc};
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.alu_op", 64'(alu_op), 64'(ALU_ADD));
    chk("rst.illegal", 64'(illegal), 64'd0);
    chk("rst.imm", 64'(imm), 64'd0);
    reset = 1'b1;

    dir("sub", 32'h40B50533, ALU_SUB, 1'b0, 32'h0, 1'b0);
    chk("sub.rd", 64'(rd), 64'd10);
    dir("addi", 32'hFFF50513, ALU_ADD, 1'b1, 32'hFFFF_FFFF, 1'b0);
    dir("srai", 32'h4055D513, ALU_ARSHIFT, 1'b1, 32'd5, 1'b0);
    dir("srai_bad", 32'h2055D513, ALU_ADD, 1'b1, 32'd5, 1'b1);
    dir("div", 32'h02B54533, M_EN ? ALU_DIV : ALU_ADD, 1'b0, 32'h0, !M_EN);
    dir("mulh", 32'h02B51533, ALU_ADD, 1'b0, 32'h0, 1'b1);
    dir("slti", 32'h80052513, ALU_SUB, 1'b1, 32'hFFFF_F800, 1'b0);
    chk("slti.set_lt", 64'(set_lt), 64'd1);
    dir("lui", 32'h12345537, ALU_ADD, 1'b0, 32'h0, 1'b0);
    chk("lui.is_alu", 64'(is_alu), 64'd0);
    step(1'b0, 32'h0, 1'b1);

    // Backpressure: three offers, only two fit, then drain in order.
    step(1'b1, 32'h00B50533, 1'b0);
    step(1'b1, 32'h00B56533, 1'b0);
    chk("bp.in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h00B57533, 1'b0);
    chk("bp.hold_op", 64'(alu_op), 64'(ALU_ADD));
    step(1'b0, 32'h0, 1'b1);
    chk("bp.second_op", 64'(alu_op), 64'(ALU_OR));
    chk("bp.in_ready2", 64'(in_ready), 64'd1);
    step(1'b0, 32'h0, 1'b1);
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Reset with both entries occupied.
    step(1'b1, 32'h00B50533, 1'b0);
    step(1'b1, 32'h00B54533, 1'b0);
    reset = 1'b0;
    step(1'b1, 32'h00B50533, 1'b1);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
